vc_frame_sync: RTL and testbench
================================

# vc_frame_sync

Per-virtual-channel frame synchroniser placed directly downstream of one output port of the YUV422 VC stream switch. It accepts the demultiplexed AXI4-Stream for a single VC and checks every line and frame against fixed geometry. It discards data until a valid start-of-frame, forwards only well-formed frame data through a registered two-entry skid buffer, and reports line and frame errors to the VDMA or video-in stage that follows.

## Interface
- FREQ_HZ, 32'd100000000, clock frequency (informational only)
- WIDTH, 16, tdata width (one YUV422 pixel per beat)
- TUSER_WIDTH, 1, tuser width; bit 0 is SOF
- TDEST_WIDTH, 10, tdest width
- VC_ID, 10'h1e2, tdest value accepted by this instance
- H_ACTIVE, 1920, beats per line (≥2)
- V_ACTIVE, 1080, lines per frame (≥1)
- CNT_WIDTH, 16, width of the column and line counters

- aclk  in  1  sole clock; all logic on its rising edge
- areset  in  1  synchronous, active-high reset
- s_axis_tvalid/tready/tdata/tlast/tuser/tdest  in/out/in/in/in/in  1/1/WIDTH/1/TUSER_WIDTH/TDEST_WIDTH  upstream VC stream
- m_axis_tvalid/tready/tdata/tlast/tuser  out/in/out/out/out  1/1/WIDTH/1/TUSER_WIDTH  downstream video stream
- frame_done  out  1  one-cycle pulse when the last beat of a complete frame is accepted
- err_short_line  out  1  pulse: tlast arrived before H_ACTIVE beats
- err_long_line  out  1  pulse: H_ACTIVE beats arrived without tlast
- err_frame  out  1  pulse: SOF arrived before V_ACTIVE lines completed
- frame_count  out  16  count of complete frames, wraps at 0xFFFF→0
- dropping  out  1  high while in WAIT_SOF or DROP

## Operation
- Accepted beat: s_axis_tvalid & s_axis_tready. Beats with tdest≠VC_ID are accepted and discarded, and do not touch the counters or state.
- States:
  - WAIT_SOF (reset state): tready=1, beats discarded.
  - PASS: forward beats.
  - DROP: tready=1, beats discarded.
- Entering a frame from WAIT_SOF or DROP: an accepted beat with tuser[0]=1 is forwarded with tuser[0]=1. Set col=1, line=0, go to PASS.
- PASS, tuser[0]=0 beat: forwarded with tuser=0 and col incremented.
  - tlast with col+1=H_ACTIVE: line complete, col←0. If line=V_ACTIVE-1: frame_done pulse, frame_count+1, go to WAIT_SOF. Otherwise line+1.
  - tlast with col+1<H_ACTIVE: forward the beat with tlast=1, pulse err_short_line, go to DROP.
  - col=H_ACTIVE-1 without tlast: forward the beat with tlast forced to 1, pulse err_long_line, go to DROP.
- PASS, tuser[0]=1 beat (premature SOF): pulse err_frame, forward the beat as a new SOF, set col=1 and line=0, stay in PASS. If the same beat also carries a line error, err_frame takes precedence and the line check is skipped.
- A SOF beat that also carries tlast is treated as a short line (H_ACTIVE≥2): forward it, pulse err_short_line, go to DROP.
- m_axis_tuser bits above bit 0 are passed through unchanged. m_axis_tdest is not provided.
- Counter widths: col and line are CNT_WIDTH bits. No wrap is possible because geometry is bounded by the parameters.

## Timing
- Reset (areset=1 at a clock edge):
  - state←WAIT_SOF, both skid entries emptied, col/line/frame_count←0.
  - m_axis_tvalid, tlast, tuser, tdata←0; all pulse outputs←0; dropping←1; s_axis_tready←0 during reset.
- In the first cycle after reset deassertion, s_axis_tready=1.
- Reset mid-frame discards both buffered beats without emitting them.
- Latency: a beat accepted in cycle N appears on m_axis in cycle N+1 when the buffer was empty.
- s_axis_tready is a register. In PASS it is 0 only when both skid entries are full.
- Sustained m_axis_tready=1 gives one beat per cycle with no bubbles.
- Handshake rules:
  - m_axis_tvalid, once high, stays high with tdata/tlast/tuser stable until m_axis_tready.
  - Output order equals accept order.
- Buffer conditions:
  - Full (2 entries) with m_axis_tready=0: s_axis_tready=0 next cycle, and no beat is lost.
  - Empty: m_axis_tvalid=0.
  - Simultaneous push and pop on a full buffer is not possible, because tready is already 0.
- Status pulses and counter update timing:
  - err_*/frame_done assert exactly one cycle, in the cycle after the triggering beat is accepted.
  - frame_count updates in that same cycle.
- Discarded beats in WAIT_SOF/DROP never reach m_axis, even while m_axis_tready=0.

## Test plan
- H_ACTIVE=8, V_ACTIVE=4: 5 idle beats, then a clean frame of 32 beats with SOF on beat 0 and tlast every 8th beat → the 5 idle beats are dropped; 32 beats are output in order with 4 tlast; frame_done pulses once; frame_count=1.
- Clean frame with m_axis_tready toggling 1,0,0,1 throughout → no loss or duplication, tdata sequence intact, and s_axis_tready drops only when the buffer holds 2 beats.
- Line 1 ends with tlast after 5 beats → 13 beats output, the last with tlast=1; err_short_line pulses; the rest of the frame is dropped; the next SOF resumes output.
- Line 2 runs 10 beats without tlast → the 8th beat of that line is output with tlast=1; err_long_line pulses; DROP until the next SOF.
- SOF arrives at line 2 col 0 → err_frame pulses; the beat is output with tuser=1; the new frame completes normally and frame_count increments by 1 only.
- Beats with tdest=10'h1e3 interleaved with the frame → ignored and absent from m_axis; asserting areset mid-frame → m_axis_tvalid=0 next cycle, counters 0, WAIT_SOF.

Source files
------------

// File: rtl/vc_frame_sync_if.sv
// AXI4-Stream bundle shared by the VC input side and the video output side of vc_frame_sync.
// The output side has no tdest consumer; the synchroniser ties it to zero.
interface vc_frame_sync_if #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 10
);
  logic                   tvalid;
  logic                   tready;
  logic [WIDTH-1:0]       tdata;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tuser, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/vc_frame_sync.sv
// Per-VC frame synchroniser: checks line/frame geometry, drops until a valid SOF and forwards
// well-formed data through a registered two-entry skid buffer with error/status pulses.
module vc_frame_sync #(
  parameter int unsigned            FREQ_HZ     = 32'd100000000,
  parameter int unsigned            WIDTH       = 16,
  parameter int unsigned            TUSER_WIDTH = 1,
  parameter int unsigned            TDEST_WIDTH = 10,
  parameter logic [TDEST_WIDTH-1:0] VC_ID       = 'h1e2,
  parameter int unsigned            H_ACTIVE    = 1920,
  parameter int unsigned            V_ACTIVE    = 1080,
  parameter int unsigned            CNT_WIDTH   = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  vc_frame_sync_if.slave          s_axis,
  vc_frame_sync_if.master         m_axis,
  output logic                    frame_done,
  output logic                    err_short_line,
  output logic                    err_long_line,
  output logic                    err_frame,
  output logic [15:0]             frame_count,
  output logic                    dropping
);

  if (H_ACTIVE < 2) begin : g_bad_h_active
    $error("H_ACTIVE must be at least 2");
  end
  if (V_ACTIVE < 1) begin : g_bad_v_active
    $error("V_ACTIVE must be at least 1");
  end
  if (FREQ_HZ == 0) begin : g_bad_freq
    $error("FREQ_HZ must be nonzero");
  end

  localparam int unsigned          BeatW    = WIDTH + 1 + TUSER_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ColLast  = CNT_WIDTH'(H_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] LineLast = CNT_WIDTH'(V_ACTIVE - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StWaitSof, StPass, StDrop} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] col_q, col_d, line_q, line_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [BeatW-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
  logic                 vld0_q, vld0_d, vld1_q, vld1_d;
  logic                 tready_q, tready_d;
  logic                 frame_done_q, frame_done_d;
  logic                 err_short_q, err_short_d;
  logic                 err_long_q, err_long_d;
  logic                 err_frame_q, err_frame_d;
  logic                 dropping_q, dropping_d;

  logic             s_tready, accept, ours, sof, pop, push, last_out;
  logic [BeatW-1:0] push_beat;

  // tready_q is left at 1 by reset; the gate keeps it low while reset is held.
  assign s_tready      = tready_q & ~areset;
  assign s_axis.tready = s_tready;
  assign accept        = s_axis.tvalid & s_tready;
  assign ours          = accept & (s_axis.tdest == VC_ID);
  assign sof           = s_axis.tuser[0];
  assign pop           = vld0_q & m_axis.tready;
  assign push_beat     = {last_out, s_axis.tuser, s_axis.tdata};

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    line_d        = line_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    err_short_d   = 1'b0;
    err_long_d    = 1'b0;
    err_frame_d   = 1'b0;
    push          = 1'b0;
    last_out      = s_axis.tlast;
    if (ours) begin
      if (state_q != StPass) begin
        if (sof) begin
          push = 1'b1;
          if (s_axis.tlast) begin
            err_short_d = 1'b1;
            state_d     = StDrop;
          end else begin
            col_d   = CntOne;
            line_d  = '0;
            state_d = StPass;
          end
        end
      end else if (sof) begin
        // A restart wins over any line check on the same beat.
        push        = 1'b1;
        err_frame_d = 1'b1;
        col_d       = CntOne;
        line_d      = '0;
      end else begin
        push = 1'b1;
        if (s_axis.tlast) begin
          if (col_q == ColLast) begin
            col_d = '0;
            if (line_q == LineLast) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = StWaitSof;
            end else begin
              line_d = line_q + CntOne;
            end
          end else begin
            err_short_d = 1'b1;
            state_d     = StDrop;
          end
        end else if (col_q == ColLast) begin
          last_out   = 1'b1;
          err_long_d = 1'b1;
          state_d    = StDrop;
        end else begin
          col_d = col_q + CntOne;
        end
      end
    end
    dropping_d = (state_d != StPass);
  end

  // Head entry always drives the output; the second entry only fills while the head stalls.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    if (pop) begin
      buf0_d = buf1_q;
      vld0_d = vld1_q;
      vld1_d = 1'b0;
    end
    if (push) begin
      if (!vld0_d) begin
        buf0_d = push_beat;
        vld0_d = 1'b1;
      end else begin
        buf1_d = push_beat;
        vld1_d = 1'b1;
      end
    end
    tready_d = ~(vld0_d & vld1_d);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= StWaitSof;
      col_q         <= '0;
      line_q        <= '0;
      frame_count_q <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      vld0_q        <= 1'b0;
      vld1_q        <= 1'b0;
      tready_q      <= 1'b1;
      frame_done_q  <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      dropping_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      line_q        <= line_d;
      frame_count_q <= frame_count_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      vld0_q        <= vld0_d;
      vld1_q        <= vld1_d;
      tready_q      <= tready_d;
      frame_done_q  <= frame_done_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      err_frame_q   <= err_frame_d;
      dropping_q    <= dropping_d;
    end
  end

  assign m_axis.tvalid = vld0_q;
  assign {m_axis.tlast, m_axis.tuser, m_axis.tdata} = buf0_q;
  assign m_axis.tdest  = '0;

  assign frame_done     = frame_done_q;
  assign err_short_line = err_short_q;
  assign err_long_line  = err_long_q;
  assign err_frame      = err_frame_q;
  assign frame_count    = frame_count_q;
  assign dropping       = dropping_q;

endmodule

// File: tb/tb_vc_frame_sync.sv
// Randomised bench for vc_frame_sync: a frame-level reference model predicts every output beat,
// status pulse and counter value, and the bench compares against it each cycle.
module tb_vc_frame_sync;
  localparam int unsigned W  = 16;
  localparam int unsigned UW = 1;
  localparam int unsigned DW = 10;
  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam logic [9:0]  VC    = 10'h1e2;
  localparam logic [9:0]  OTHER = 10'h1e3;

  logic        aclk = 1'b0;
  logic        areset;
  logic        frame_done, err_short_line, err_long_line, err_frame, dropping;
  logic [15:0] frame_count;

  vc_frame_sync_if #(.WIDTH(W), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW)) s_if ();
  vc_frame_sync_if #(.WIDTH(W), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW)) m_if ();

  vc_frame_sync #(
    .WIDTH(W), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW), .VC_ID(VC),
    .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(16)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .frame_done     (frame_done),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_frame      (err_frame),
    .frame_count    (frame_count),
    .dropping       (dropping)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {logic [15:0] data; logic last; logic user; logic [9:0] dest;} beat_t;
  typedef struct packed {logic [15:0] data; logic last; logic user;} obeat_t;

  beat_t  stim_q[$];
  obeat_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference model: inside a frame or not, position in the frame, completed frames.
  bit in_frame;
  int col, line, frames;
  bit exp_done, exp_short, exp_long, exp_ferr;

  int out_beats, out_lasts, done_seen, short_seen, long_seen, ferr_seen;
  int rdy_mode, valid_pct, il_pct, cyc;
  bit held;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void emit(beat_t b, logic last);
    obeat_t o;
    o.data = b.data;
    o.last = last;
    o.user = b.user;
    exp_q.push_back(o);
  endfunction

  function automatic void model_accept(beat_t b);
    if (b.dest != VC) return;
    if (!in_frame) begin
      if (!b.user) return;
      emit(b, b.last);
      if (b.last) exp_short = 1;
      else begin in_frame = 1; col = 1; line = 0; end
    end else if (b.user) begin
      emit(b, b.last);
      exp_ferr = 1; col = 1; line = 0;
    end else begin
      col++;
      if (b.last && col == H) begin
        emit(b, 1'b1);
        col = 0;
        if (line == V - 1) begin exp_done = 1; frames++; in_frame = 0; end
        else line++;
      end else if (b.last) begin
        emit(b, 1'b1); exp_short = 1; in_frame = 0;
      end else if (col == H) begin
        emit(b, 1'b1); exp_long = 1; in_frame = 0;
      end else begin
        emit(b, 1'b0);
      end
    end
  endfunction

  function automatic void add_beat(logic last, logic user, logic [9:0] dest);
    beat_t b;
    b.data = 16'($urandom);
    b.last = last;
    b.user = user;
    b.dest = dest;
    stim_q.push_back(b);
  endfunction

  function automatic void add_line(int n, bit sof, bit last_end);
    for (int i = 0; i < n; i++) begin
      add_beat(last_end && (i == n - 1), sof && (i == 0), VC);
      if ($urandom_range(99) < il_pct)
        add_beat(1'($urandom_range(1)), 1'($urandom_range(1)), OTHER);
    end
  endfunction

  function automatic void add_frame();
    for (int l = 0; l < V; l++) add_line(H, l == 0, 1);
  endfunction

  // kind: 0 clean, 1 short line, 2 long line, 3 frame cut off before its last line.
  function automatic void add_faulty(int kind);
    int el;
    el = (kind == 3) ? int'($urandom_range(V - 1, 1)) : int'($urandom_range(V - 1));
    for (int l = 0; l < V; l++) begin
      if (kind == 3 && l == el) break;
      if (kind == 1 && l == el) add_line(int'($urandom_range(H - 1, 1)), l == 0, 1);
      else if (kind == 2 && l == el) add_line(H + int'($urandom_range(3, 1)), l == 0, 0);
      else add_line(H, l == 0, 1);
    end
  endfunction

  task automatic start(int mode, int pct, int il);
    rdy_mode = mode; valid_pct = pct; il_pct = il;
    out_beats = 0; out_lasts = 0; done_seen = 0; short_seen = 0; long_seen = 0; ferr_seen = 0;
  endtask

  task automatic run(int budget, bit drain);
    int  n;
    bit  acc, pop;
    n = 0;
    forever begin
      @(posedge aclk); #1;
      check("m_tvalid", m_if.tvalid, exp_q.size() != 0);
      if (m_if.tvalid && exp_q.size() != 0) begin
        check("m_tdata", m_if.tdata, exp_q[0].data);
        check("m_tlast", m_if.tlast, exp_q[0].last);
        check("m_tuser", m_if.tuser, exp_q[0].user);
      end
      check("s_tready", s_if.tready, exp_q.size() < 2);
      check("frame_done", frame_done, exp_done);
      check("err_short_line", err_short_line, exp_short);
      check("err_long_line", err_long_line, exp_long);
      check("err_frame", err_frame, exp_ferr);
      check("frame_count", frame_count, 16'(frames));
      check("dropping", dropping, !in_frame);
      done_seen += frame_done; short_seen += err_short_line;
      long_seen += err_long_line; ferr_seen += err_frame;
      exp_done = 0; exp_short = 0; exp_long = 0; exp_ferr = 0;
      n++;
      if ((drain && stim_q.size() == 0 && exp_q.size() == 0 && !held) || n >= budget) begin
        if (drain && n >= budget) check("drain_timeout", 32'd0, 32'd1);
        s_if.tvalid = 1'b0; m_if.tready = 1'b0; held = 0;
        break;
      end
      case (rdy_mode)
        0:       m_if.tready = ($urandom_range(99) < 70);
        1:       m_if.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       m_if.tready = 1'b1;
        default: m_if.tready = 1'b0;
      endcase
      cyc++;
      if (!held) begin
        if (stim_q.size() != 0 && $urandom_range(99) < valid_pct) begin
          s_if.tvalid = 1'b1;
          s_if.tdata  = stim_q[0].data;
          s_if.tlast  = stim_q[0].last;
          s_if.tuser  = stim_q[0].user;
          s_if.tdest  = stim_q[0].dest;
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
      acc = s_if.tvalid && s_if.tready;
      pop = m_if.tvalid && m_if.tready;
      if (pop) begin
        out_beats++;
        out_lasts += m_if.tlast;
        if (exp_q.size() != 0) exp_q.delete(0);
      end
      if (acc) begin
        model_accept(stim_q[0]);
        stim_q.delete(0);
        held = 0;
      end else begin
        held = s_if.tvalid;
      end
    end
  endtask

  task automatic do_reset();
    areset = 1'b1; s_if.tvalid = 1'b0; m_if.tready = 1'b0; held = 0;
    @(posedge aclk); #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_dropping", dropping, 1);
    check("rst_pulses", {frame_done, err_short_line, err_long_line, err_frame}, 0);
    areset = 1'b0;
    in_frame = 0; col = 0; line = 0; frames = 0;
    exp_q.delete(); stim_q.delete();
    exp_done = 0; exp_short = 0; exp_long = 0; exp_ferr = 0;
    #1;
    check("post_rst_s_tready", s_if.tready, 1);
  endtask

  initial begin
    areset = 1'b1; cyc = 0; held = 0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0; s_if.tdest = '0;
    m_if.tready = 1'b0;
    do_reset();

    start(0, 80, 0);
    for (int i = 0; i < 5; i++) add_beat(1'($urandom_range(1)), 1'b0, VC);
    add_frame();
    run(2000, 1);
    check("idle_out_beats", out_beats, 32);
    check("idle_out_lasts", out_lasts, 4);
    check("idle_done", done_seen, 1);
    check("idle_frame_count", frame_count, 1);

    start(1, 100, 0);
    add_frame();
    run(2000, 1);
    check("toggle_out_beats", out_beats, 32);
    check("toggle_frame_count", frame_count, 2);

    start(0, 80, 0);
    add_line(H, 1, 1); add_line(5, 0, 1); add_line(H, 0, 1); add_line(H, 0, 1);
    add_frame();
    run(2000, 1);
    check("short_out_beats", out_beats, 45);
    check("short_pulses", short_seen, 1);
    check("short_frame_count", frame_count, 3);

    start(0, 80, 0);
    add_line(H, 1, 1); add_line(H, 0, 1); add_line(10, 0, 0); add_line(H, 0, 1);
    add_frame();
    run(2000, 1);
    check("long_out_beats", out_beats, 56);
    check("long_pulses", long_seen, 1);
    check("long_frame_count", frame_count, 4);

    start(0, 80, 0);
    add_line(H, 1, 1); add_line(H, 0, 1);
    add_frame();
    run(2000, 1);
    check("presof_out_beats", out_beats, 48);
    check("presof_pulses", ferr_seen, 1);
    check("presof_done", done_seen, 1);
    check("presof_frame_count", frame_count, 5);

    start(0, 90, 30);
    add_frame();
    run(2000, 1);
    check("tdest_out_beats", out_beats, 32);
    check("tdest_frame_count", frame_count, 6);

    start(0, 70, 15);
    for (int f = 0; f < 12; f++) add_faulty(int'($urandom_range(3)));
    add_frame();
    run(8000, 1);

    start(3, 100, 0);
    add_frame();
    run(12, 0);
    check("midrst_buffered", m_if.tvalid, 1);
    do_reset();
    start(2, 100, 0);
    run(20, 1);
    add_frame();
    run(2000, 1);
    check("midrst_out_beats", out_beats, 32);
    check("midrst_frame_count", frame_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
